fetch_stage: RTL

//   Instruction-fetch stage and IF/ID pipeline register, directly upstream of the opcode decoder.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register; resolves j/jal locally, takes execute redirects.
// Optional FETCH_PERF_EN adds saturating fetch/bubble performance counters.
module fetch_stage #(
  parameter int unsigned PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  input  logic [31:0]     imem_q,
  output logic [PC_W-1:0] imem_addr,
  output logic [31:0]     ifid_insn,
  output logic [PC_W-1:0] ifid_pc_plus1,
  output logic [4:0]      ifid_op,
  output logic            ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]      OpJ   = 5'b00001;
  localparam logic [4:0]      OpJal = 5'b00011;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     insn_q, insn_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_inc;
  logic            dj;
  logic            take_fetch;
  logic            take_bubble;

  assign pc_inc = pc_q + PcOne;
  assign dj     = valid_q & ((insn_q[31:27] == OpJ) | (insn_q[31:27] == OpJal));

  // Priority mux: redirect > stall > direct jump > sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    insn_d      = insn_q;
    pc1_d       = pc1_q;
    valid_d     = valid_q;
    take_fetch  = 1'b0;
    take_bubble = 1'b0;
    if (ex_redirect) begin
      pc_d        = ex_target;
      insn_d      = 32'h0;
      valid_d     = 1'b0;
      take_bubble = 1'b1;
    end else if (stall) begin
      // hold everything; a pending direct jump waits for the stall to clear
    end else if (dj) begin
      pc_d        = insn_q[PC_W-1:0];
      insn_d      = 32'h0;
      valid_d     = 1'b0;
      take_bubble = 1'b1;
    end else begin
      pc_d       = pc_inc;
      insn_d     = imem_q;
      pc1_d      = pc_inc;
      valid_d    = 1'b1;
      take_fetch = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      insn_q  <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_insn     = insn_q;
  assign ifid_pc_plus1 = pc1_q;
  assign ifid_op       = insn_q[31:27];
  assign ifid_valid    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubbles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (take_fetch && (fetched_q != 32'hFFFF_FFFF)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (take_bubble && (bubbles_q != 32'hFFFF_FFFF)) begin
        bubbles_q <= bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  logic unused_perf;
  assign unused_perf = take_fetch ^ take_bubble;
`endif

endmodule
